// File: rtl/hex_display_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : hex_display_arbiter
// Purpose  : Arbitrates ownership of six 7-segment displays between two
//            requesters. The owner's accepted writes load a 24-bit hex value
//            and a 6-bit blank mask. The segments are decoded and registered
//            one edge after the write. An owner that holds the displays
//            without writing for TIMEOUT_CYCLES loses them to a waiting
//            requester.
// Ports    : clk_clk        - system clock, rising edge
//            reset_reset_n  - asynchronous active-low reset
//            req0/req1      - ownership requests
//            wr0/wr1        - write strobes (honoured only from current owner)
//            data0/data1    - six hex nibbles, nibble k -> digit k
//            blank0/blank1  - per-digit blank mask, bit k=1 blanks digit k
//            gnt0/gnt1      - registered grants (mutually exclusive)
//            preempt        - one-cycle pulse on a timeout-forced hand-over
//            hex0..hex5     - registered active-low segments, bit order g..a
// Revision : 1.0 - initial release
// ============================================================================
module hex_display_arbiter #(
  parameter int TIMEOUT_CYCLES = 50000000,
  parameter int CNT_W          = 26
) (
  input  logic        clk_clk,
  input  logic        reset_reset_n,
  input  logic        req0,
  input  logic        req1,
  input  logic        wr0,
  input  logic        wr1,
  input  logic [23:0] data0,
  input  logic [23:0] data1,
  input  logic [5:0]  blank0,
  input  logic [5:0]  blank1,
  output logic        gnt0,
  output logic        gnt1,
  output logic        preempt,
  output logic [6:0]  hex0,
  output logic [6:0]  hex1,
  output logic [6:0]  hex2,
  output logic [6:0]  hex3,
  output logic [6:0]  hex4,
  output logic [6:0]  hex5
);

  localparam logic [CNT_W-1:0] c_cnt_max = CNT_W'(TIMEOUT_CYCLES - 1);

  // One-hot owner encoding so each grant is a flop output directly.
  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_OWN0 = 2'b01,
    ST_OWN1 = 2'b10
  } state_t;

  state_t             r_state;
  state_t             w_next_state;
  logic               w_preempt;
  logic               r_preempt;
  logic [CNT_W-1:0]   r_cnt;
  logic               r_last_owner;
  logic [23:0]        r_value;
  logic [5:0]         r_mask;
  logic [41:0]        w_seg;
  logic [41:0]        r_hex;
  logic               w_acc0;
  logic               w_acc1;

  assign gnt0    = r_state[0];
  assign gnt1    = r_state[1];
  assign preempt = r_preempt;

  // A write counts only when the writer already holds the registered grant.
  assign w_acc0 = wr0 & gnt0;
  assign w_acc1 = wr1 & gnt1;

  always_ff @(posedge clk_clk or negedge reset_reset_n) begin
    if (!reset_reset_n) begin
      r_state   <= ST_IDLE;
      r_preempt <= 1'b0;
    end else begin
      r_state   <= w_next_state;
      r_preempt <= w_preempt;
    end
  end

  always_comb begin
    w_next_state = r_state;
    w_preempt    = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (req0 && req1)
          w_next_state = r_last_owner ? ST_OWN0 : ST_OWN1;
        else if (req0)
          w_next_state = ST_OWN0;
        else if (req1)
          w_next_state = ST_OWN1;
      end
      ST_OWN0: begin
        if (!req0) begin
          w_next_state = req1 ? ST_OWN1 : ST_IDLE;
        end else if (req1 && (r_cnt == c_cnt_max) && !w_acc0) begin
          // A write in the expiry cycle keeps the owner in place.
          w_next_state = ST_OWN1;
          w_preempt    = 1'b1;
        end
      end
      ST_OWN1: begin
        if (!req1) begin
          w_next_state = req0 ? ST_OWN0 : ST_IDLE;
        end else if (req0 && (r_cnt == c_cnt_max) && !w_acc1) begin
          w_next_state = ST_OWN0;
          w_preempt    = 1'b1;
        end
      end
      default: w_next_state = ST_IDLE;
    endcase
  end

  // Hold counter: restarts on any state change or accepted write,
  // otherwise counts owned cycles and parks at the expiry value.
  always_ff @(posedge clk_clk or negedge reset_reset_n) begin
    if (!reset_reset_n) begin
      r_cnt <= '0;
    end else if ((w_next_state != r_state) || w_acc0 || w_acc1) begin
      r_cnt <= '0;
    end else if ((r_state != ST_IDLE) && (r_cnt != c_cnt_max)) begin
      r_cnt <= r_cnt + CNT_W'(1);
    end
  end

  // Reset value 1 makes requester 0 win the first simultaneous request.
  always_ff @(posedge clk_clk or negedge reset_reset_n) begin
    if (!reset_reset_n)
      r_last_owner <= 1'b1;
    else if (w_next_state == ST_OWN0)
      r_last_owner <= 1'b0;
    else if (w_next_state == ST_OWN1)
      r_last_owner <= 1'b1;
  end

  // Display contents persist until the next accepted write, regardless
  // of ownership; a write on the releasing edge still lands.
  always_ff @(posedge clk_clk or negedge reset_reset_n) begin
    if (!reset_reset_n) begin
      r_value <= '0;
      r_mask  <= 6'b111111;
    end else if (w_acc0) begin
      r_value <= data0;
      r_mask  <= blank0;
    end else if (w_acc1) begin
      r_value <= data1;
      r_mask  <= blank1;
    end
  end

  function automatic logic [6:0] seg_decode(input logic [3:0] nib);
    logic [6:0] seg;
    case (nib)
      4'h0: seg = 7'b1000000;
      4'h1: seg = 7'b1111001;
      4'h2: seg = 7'b0100100;
      4'h3: seg = 7'b0110000;
      4'h4: seg = 7'b0011001;
      4'h5: seg = 7'b0010010;
      4'h6: seg = 7'b0000010;
      4'h7: seg = 7'b1111000;
      4'h8: seg = 7'b0000000;
      4'h9: seg = 7'b0010000;
      4'hA: seg = 7'b0001000;
      4'hB: seg = 7'b0000011;
      4'hC: seg = 7'b1000110;
      4'hD: seg = 7'b0100001;
      4'hE: seg = 7'b0000110;
      default: seg = 7'b0001110;
    endcase
    return seg;
  endfunction

  for (genvar k = 0; k < 6; k++) begin : g_digit
    assign w_seg[k*7 +: 7] = r_mask[k] ? 7'b1111111 : seg_decode(r_value[k*4 +: 4]);
  end

  always_ff @(posedge clk_clk or negedge reset_reset_n) begin
    if (!reset_reset_n)
      r_hex <= {42{1'b1}};
    else
      r_hex <= w_seg;
  end

  assign hex0 = r_hex[6:0];
  assign hex1 = r_hex[13:7];
  assign hex2 = r_hex[20:14];
  assign hex3 = r_hex[27:21];
  assign hex4 = r_hex[34:28];
  assign hex5 = r_hex[41:35];

endmodule
`default_nettype wire

// File: tb/tb_hex_display_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_hex_display_arbiter
// Purpose  : Self-checking bench for hex_display_arbiter. A vector table
//            covers arbitration, write filtering and digit decode.
//            Hand-written sequences cover timeout preemption, cancellation of
//            a preemption by a write, and asynchronous reset.
// Revision : 1.0 - initial release
// ============================================================================
module tb_hex_display_arbiter;

  localparam int TMO = 8;

  // Expected segment images, packed hex5..hex0.
  localparam logic [41:0] H_BLANK  = {6{7'h7F}};
  localparam logic [41:0] H_12AB3F = {7'h79, 7'h24, 7'h08, 7'h03, 7'h30, 7'h0E};
  localparam logic [41:0] H_345678 = {7'h30, 7'h19, 7'h12, 7'h02, 7'h78, 7'h00};
  localparam logic [41:0] H_EDGE   = {7'h7F, 7'h40, 7'h40, 7'h40, 7'h40, 7'h7F};
  localparam logic [41:0] H_ONES   = {6{7'h79}};

  logic        clk_clk = 1'b0;
  logic        reset_reset_n;
  logic        req0, req1, wr0, wr1;
  logic [23:0] data0, data1;
  logic [5:0]  blank0, blank1;
  logic        gnt0, gnt1, preempt;
  logic [6:0]  hex0, hex1, hex2, hex3, hex4, hex5;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk_clk = ~clk_clk;

  hex_display_arbiter #(
    .TIMEOUT_CYCLES(TMO),
    .CNT_W(4)
  ) dut (
    .clk_clk(clk_clk),
    .reset_reset_n(reset_reset_n),
    .req0(req0),
    .req1(req1),
    .wr0(wr0),
    .wr1(wr1),
    .data0(data0),
    .data1(data1),
    .blank0(blank0),
    .blank1(blank1),
    .gnt0(gnt0),
    .gnt1(gnt1),
    .preempt(preempt),
    .hex0(hex0),
    .hex1(hex1),
    .hex2(hex2),
    .hex3(hex3),
    .hex4(hex4),
    .hex5(hex5)
  );

  // Observed word: {gnt0, gnt1, preempt, hex5..hex0}
  logic [44:0] obs;
  assign obs = {gnt0, gnt1, preempt, hex5, hex4, hex3, hex2, hex1, hex0};

  typedef struct {
    logic        r0, r1, w0, w1;
    logic [23:0] d0, d1;
    logic [5:0]  b0, b1;
    logic [44:0] exp;
  } vec_t;

  vec_t tbl[$];

  function automatic vec_t mk(input logic r0, input logic r1, input logic w0,
                              input logic w1, input logic [23:0] d0,
                              input logic [23:0] d1, input logic [5:0] b0,
                              input logic [5:0] b1, input logic [2:0] ctl,
                              input logic [41:0] hx);
    vec_t v;
    v.r0 = r0; v.r1 = r1; v.w0 = w0; v.w1 = w1;
    v.d0 = d0; v.d1 = d1; v.b0 = b0; v.b1 = b1;
    v.exp = {ctl, hx};
    return v;
  endfunction

  task automatic check(input string name, input logic [44:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got gnt0/gnt1/preempt=%b hex=%h, expected %b hex=%h",
               name, obs[44:42], obs[41:0], exp[44:42], exp[41:0]);
    end
  endtask

  // Advance one clock and settle away from the edge.
  task automatic tick();
    @(posedge clk_clk);
    #1;
  endtask

  task automatic idle_inputs();
    req0 = 0; req1 = 0; wr0 = 0; wr1 = 0;
    data0 = '0; data1 = '0; blank0 = '0; blank1 = '0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1);
  end

  initial begin
    // ctl = {gnt0, gnt1, preempt}
    tbl.push_back(mk(1,1,0,0,24'h0,     24'h0,     6'b0,      6'b0, 3'b100, H_BLANK));
    tbl.push_back(mk(1,1,1,0,24'h12AB3F,24'h0,     6'b0,      6'b0, 3'b100, H_BLANK));
    tbl.push_back(mk(1,1,0,0,24'h0,     24'h0,     6'b0,      6'b0, 3'b100, H_12AB3F));
    tbl.push_back(mk(0,1,0,1,24'h0,     24'hFFFFFF,6'b0,      6'b0, 3'b010, H_12AB3F));
    tbl.push_back(mk(0,1,1,0,24'h0,     24'h0,     6'b0,      6'b0, 3'b010, H_12AB3F));
    tbl.push_back(mk(0,1,0,0,24'h0,     24'h0,     6'b0,      6'b0, 3'b010, H_12AB3F));
    tbl.push_back(mk(0,1,0,1,24'h0,     24'h345678,6'b0,      6'b0, 3'b010, H_12AB3F));
    tbl.push_back(mk(0,0,0,0,24'h0,     24'h0,     6'b0,      6'b0, 3'b000, H_345678));
    tbl.push_back(mk(0,0,1,0,24'hFFFFFF,24'h0,     6'b0,      6'b0, 3'b000, H_345678));
    tbl.push_back(mk(0,0,0,0,24'h0,     24'h0,     6'b0,      6'b0, 3'b000, H_345678));
    tbl.push_back(mk(1,1,0,0,24'h0,     24'h0,     6'b0,      6'b0, 3'b100, H_345678));
    tbl.push_back(mk(1,0,1,0,24'h000000,24'h0,     6'b100001, 6'b0, 3'b100, H_345678));
    tbl.push_back(mk(0,0,1,0,24'h111111,24'h0,     6'b0,      6'b0, 3'b000, H_EDGE));
    tbl.push_back(mk(1,1,0,0,24'h0,     24'h0,     6'b0,      6'b0, 3'b010, H_ONES));
    tbl.push_back(mk(0,0,0,0,24'h0,     24'h0,     6'b0,      6'b0, 3'b000, H_ONES));

    idle_inputs();
    reset_reset_n = 0;
    tick();
    tick();
    check("reset_state", {3'b000, H_BLANK});
    reset_reset_n = 1;

    for (int i = 0; i < tbl.size(); i++) begin
      req0 = tbl[i].r0; req1 = tbl[i].r1; wr0 = tbl[i].w0; wr1 = tbl[i].w1;
      data0 = tbl[i].d0; data1 = tbl[i].d1; blank0 = tbl[i].b0; blank1 = tbl[i].b1;
      tick();
      check($sformatf("vec%0d", i), tbl[i].exp);
    end

    // Timeout preemption with a non-owner writing throughout.
    idle_inputs();
    req0 = 1;
    tick();
    check("tmo_entry", {3'b100, H_ONES});
    req1 = 1; wr1 = 1; data1 = 24'hFFFFFF;
    for (int k = 1; k < TMO; k++) begin
      tick();
      check($sformatf("tmo_hold%0d", k), {3'b100, H_ONES});
    end
    tick();
    check("tmo_preempt", {3'b011, H_ONES});
    wr1 = 0;
    tick();
    check("tmo_pulse_end", {3'b010, H_ONES});

    // A write in the expiry cycle cancels the preemption.
    req0 = 0; req1 = 0;
    tick();
    check("tmo2_idle", {3'b000, H_ONES});
    req0 = 1;
    tick();
    check("tmo2_entry", {3'b100, H_ONES});
    req1 = 1;
    for (int k = 1; k < TMO; k++) begin
      tick();
      check($sformatf("tmo2_hold%0d", k), {3'b100, H_ONES});
    end
    wr0 = 1; data0 = 24'h000000; blank0 = 6'b100001;
    tick();
    check("tmo2_cancel", {3'b100, H_ONES});
    wr0 = 0;
    tick();
    check("tmo2_hex", {3'b100, H_EDGE});
    for (int k = 2; k < TMO; k++) begin
      tick();
      check($sformatf("tmo2_rehold%0d", k), {3'b100, H_EDGE});
    end
    tick();
    check("tmo2_preempt", {3'b011, H_EDGE});

    // Asynchronous reset while requester 1 is writing.
    wr1 = 1; data1 = 24'h123456; blank1 = 6'b0;
    #2;
    reset_reset_n = 0;
    #1;
    check("reset_async", {3'b000, H_BLANK});
    idle_inputs();
    tick();
    tick();
    reset_reset_n = 1;
    tick();
    check("reset_discard0", {3'b000, H_BLANK});
    tick();
    check("reset_discard1", {3'b000, H_BLANK});
    req0 = 1; req1 = 1;
    tick();
    check("post_reset_arb", {3'b100, H_BLANK});

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/hex_display_arbiter.md
HEX_DISPLAY_ARBITER -- requirements
Module: hex_display_arbiter

Interface
REQ-001 Parameter TIMEOUT_CYCLES, default 50000000: cycles an owner may hold the displays with no accepted write before a waiting requester preempts it (1 s at 50 MHz).
REQ-002 Parameter CNT_W, default 26: width of the hold-timeout counter; SHALL satisfy 2^CNT_W >= TIMEOUT_CYCLES.
REQ-003 clk_clk  in  1  single system clock; all state changes on its rising edge.
REQ-004 reset_reset_n  in  1  asynchronous, active-low reset.
REQ-005 req0, req1  in  1 each  display-ownership request from requester 0 and requester 1.
REQ-006 wr0, wr1  in  1 each  write strobe from each requester, one value per cycle.
REQ-007 data0, data1  in  24 each  six hex nibbles; nibble k drives digit k.
REQ-008 blank0, blank1  in  6 each  per-digit blank mask; bit k=1 blanks digit k.
REQ-009 gnt0, gnt1  out  1 each  registered grant; never both high.
REQ-010 preempt  out  1  one-cycle pulse on a timeout-forced ownership change.
REQ-011 hex0..hex5  out  7 each  registered active-low segments, bit order g..a.

Function
REQ-012 The state machine SHALL have three states: IDLE, OWN0 and OWN1; gnt0=1 only in OWN0, and gnt1=1 only in OWN1.
REQ-013 IDLE: req0 only -> OWN0; req1 only -> OWN1; both -> the requester not in the last_owner register; neither -> stay in IDLE.
REQ-014 Grant latency from IDLE SHALL be exactly one cycle: req sampled high at edge N gives gnt high after edge N.
REQ-015 OWNx with req_x low: go to OWNy if req_y is high (direct hand-over, no IDLE cycle); else go to IDLE.
REQ-016 last_owner SHALL update to x on every entry to OWNx.
REQ-017 The hold counter SHALL clear on state entry and on every accepted write.
REQ-018 Otherwise the hold counter SHALL increment each cycle in OWNx, saturating at TIMEOUT_CYCLES-1.
REQ-019 Timeout preemption: in OWNx with req_x high, counter == TIMEOUT_CYCLES-1, req_y high and no accepted write that cycle -> go to OWNy and pulse preempt for one cycle.
REQ-020 An accepted write in the expiry cycle SHALL cancel that preemption.
REQ-021 A write is accepted only when wr_x=1 and gnt_x=1 (the registered value) in the same cycle.
REQ-022 Writes from a non-owner, or in IDLE, SHALL be ignored with no side effects.
REQ-023 An accepted write on the edge where ownership is lost (release or preemption) SHALL still be applied.
REQ-024 An accepted write SHALL load data_x and blank_x into the value and mask registers; hex outputs update on the following edge (two-edge latency from wr to pins).
REQ-025 Digit encoding (active-low, g..a) SHALL be: 0=1000000, 1=1111001, 2=0100100, 3=0110000, 4=0011001, 5=0010010, 6=0000010, 7=1111000, 8=0000000, 9=0010000, A=0001000, b=0000011, C=1000110, d=0100001, E=0000110, F=0001110.
REQ-026 A blanked digit SHALL output 1111111.
REQ-027 The displayed value SHALL persist across ownership changes and IDLE until the next accepted write.

Reset
REQ-028 Asserting reset_reset_n low SHALL immediately force: state IDLE, gnt0=gnt1=0, preempt=0, counter=0, last_owner=1, value=0, mask=111111, all hex=1111111.
REQ-029 Reset mid-ownership SHALL discard any in-flight write.
REQ-030 After deassertion, first arbitration SHALL occur on the next rising edge, so simultaneous requests grant requester 0 first.

Verification
REQ-031 Reset then req0=req1=1 at same edge -> gnt0=1 after one edge; drop req0 -> gnt1=1 next edge, gnt0=0 same edge.
REQ-032 Owner 0 writes data0=0x12AB3F, blank0=000000 -> after two edges hex5..hex0 = 1, 2, A, b, 3, F encodings.
REQ-033 wr1 with data1=0xFFFFFF while gnt1=0 -> hex outputs unchanged, counter unchanged.
REQ-034 TIMEOUT_CYCLES=8, owner 0 idle with req1 held -> gnt1=1 and preempt pulse exactly 8 cycles after grant entry; repeat with wr0 on the expiry cycle -> no preemption.
REQ-035 Write blank0=100001 with data0=0x000000 -> hex5 and hex0 = 1111111, others 1000000.
REQ-036 Assert reset mid-write -> all hex=1111111, gnt0=gnt1=0 immediately.
